// File: rtl/ex_forward_ctrl_pkg.sv
// Shared types for the EX-stage forwarding / hazard controller.
// The tracker entry and the bubble constant are used by the controller and its hit comparators.
package ex_forward_ctrl_pkg;

    // The tracker rd field is sized for the widest register index the controller supports.
    localparam int TRK_RD_W = 8;

    localparam int TRK_EX  = 0;
    localparam int TRK_MEM = 1;
    localparam int TRK_WB  = 2;

    typedef struct packed {
        logic                valid;
        logic [TRK_RD_W-1:0] rd;
        logic                wen;
        logic                isLoad;
    } trk_entry_t;

    localparam trk_entry_t TRK_BUBBLE = {1'b0, {TRK_RD_W{1'b0}}, 1'b0, 1'b0};

endpackage

// File: rtl/ex_forward_hit.sv
// Combinational RAW-hit compare of one ID source against one pipeline tracker entry.
// Register x0 never matches because it is hardwired to zero.
module ex_forward_hit
    import ex_forward_ctrl_pkg::*;
(
    input  logic                i_valid,
    input  logic                i_wen,
    input  logic [TRK_RD_W-1:0] i_rd,
    input  logic [TRK_RD_W-1:0] i_rs,
    input  logic                i_ren,
    output logic                o_hit
);

    assign o_hit = i_valid & i_wen & i_ren & (i_rs == i_rd) & (i_rs != '0);

endmodule

// File: rtl/ex_forward_ctrl.sv
// EX-stage operand forwarding and load-use / RAW stall controller.
// Define FORWARD_CTRL_FORWARD_EN for bypassing; otherwise it stalls on any in-flight RAW hazard.
module ex_forward_ctrl
    import ex_forward_ctrl_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NREG_BITS-1:0] id_rs1,
    input  logic [NREG_BITS-1:0] id_rs2,
    input  logic                 id_rs1_ren,
    input  logic                 id_rs2_ren,
    input  logic [NREG_BITS-1:0] id_rd,
    input  logic                 id_rd_wen,
    input  logic                 id_is_load,
    input  logic                 pipe_hold,
    input  logic                 ex_flush,
    output logic                 exu_src1_forward_ex,
    output logic                 exu_src2_forward_ex,
    output logic                 exu_src1_forward_mem,
    output logic                 exu_src2_forward_mem,
    output logic                 id_stall,
    output logic [XLEN-1:0]      stall_cnt
);

    trk_entry_t          r_trk [3];
    logic [XLEN-1:0]     r_stallCnt;
    logic [TRK_RD_W-1:0] w_rs [2];
    logic [1:0]          w_ren;
    logic [2:0][1:0]     w_hit;
    trk_entry_t          w_idEntry;
    logic                w_stall;
    logic                w_bubble;
    logic                w_unused;

    assign w_rs[0]   = TRK_RD_W'(id_rs1);
    assign w_rs[1]   = TRK_RD_W'(id_rs2);
    assign w_ren     = {id_rs2_ren, id_rs1_ren};
    assign w_idEntry = {1'b1, TRK_RD_W'(id_rd), id_rd_wen, id_is_load};

    // w_hit[tracker][source], source 0 = rs1, source 1 = rs2.
    for (genvar t = 0; t < 3; t++) begin : g_trk
        for (genvar s = 0; s < 2; s++) begin : g_src
            ex_forward_hit u_hit (
                .i_valid (r_trk[t].valid),
                .i_wen   (r_trk[t].wen),
                .i_rd    (r_trk[t].rd),
                .i_rs    (w_rs[s]),
                .i_ren   (w_ren[s]),
                .o_hit   (w_hit[t][s])
            );
        end
    end

`ifdef FORWARD_CTRL_FORWARD_EN
    assign w_stall = id_valid & (w_hit[TRK_EX][0] | w_hit[TRK_EX][1]) & r_trk[TRK_EX].isLoad;
`else
    assign w_stall = id_valid & (|w_hit);
`endif

    assign w_bubble  = w_stall | ex_flush | ~id_valid;
    assign id_stall  = w_stall;
    assign stall_cnt = r_stallCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 3; t++) begin
                r_trk[t] <= TRK_BUBBLE;
            end
            r_stallCnt <= '0;
        end else if (!pipe_hold) begin
            r_trk[TRK_WB]  <= r_trk[TRK_MEM];
            r_trk[TRK_MEM] <= r_trk[TRK_EX];
            r_trk[TRK_EX]  <= w_bubble ? TRK_BUBBLE : w_idEntry;
            if (w_stall) begin
                r_stallCnt <= r_stallCnt + XLEN'(1);
            end
        end
    end

`ifdef FORWARD_CTRL_FORWARD_EN
    logic [1:0] r_fwdEx;
    logic [1:0] r_fwdMem;

    // The youngest producer wins, so a MEM-stage match is masked by an EX-stage match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwdEx  <= '0;
            r_fwdMem <= '0;
        end else if (!pipe_hold) begin
            if (w_bubble) begin
                r_fwdEx  <= '0;
                r_fwdMem <= '0;
            end else begin
                r_fwdEx  <= w_hit[TRK_EX];
                r_fwdMem <= w_hit[TRK_MEM] & ~w_hit[TRK_EX];
            end
        end
    end

    assign exu_src1_forward_ex  = r_fwdEx[0];
    assign exu_src2_forward_ex  = r_fwdEx[1];
    assign exu_src1_forward_mem = r_fwdMem[0];
    assign exu_src2_forward_mem = r_fwdMem[1];
`else
    assign exu_src1_forward_ex  = 1'b0;
    assign exu_src2_forward_ex  = 1'b0;
    assign exu_src1_forward_mem = 1'b0;
    assign exu_src2_forward_mem = 1'b0;
`endif

    // Fields that only one build variant consumes are folded here so neither variant leaves them dangling.
    assign w_unused = ^{r_trk[TRK_EX].isLoad, r_trk[TRK_MEM].isLoad, r_trk[TRK_WB].isLoad, w_hit[TRK_WB]};

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Scoreboard bench for ex_forward_ctrl: directed instruction sequences for both build variants.
// Expected values are queued by the stimulus and checked by an independent monitor each cycle.
module tb_ex_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_ren;
    logic        id_rs2_ren;
    logic [4:0]  id_rd;
    logic        id_rd_wen;
    logic        id_is_load;
    logic        pipe_hold;
    logic        ex_flush;
    logic        exu_src1_forward_ex;
    logic        exu_src2_forward_ex;
    logic        exu_src1_forward_mem;
    logic        exu_src2_forward_mem;
    logic        id_stall;
    logic [63:0] stall_cnt;

    typedef struct {
        int          step;
        logic        stall;
        logic [3:0]  fwd;
        logic [63:0] cnt;
    } expect_t;

    expect_t expQ[$];
    int      nCompared   = 0;
    int      nMismatched = 0;
    int      stepNum     = 0;

    ex_forward_ctrl #(.XLEN(64), .NREG_BITS(5)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .id_valid             (id_valid),
        .id_rs1               (id_rs1),
        .id_rs2               (id_rs2),
        .id_rs1_ren           (id_rs1_ren),
        .id_rs2_ren           (id_rs2_ren),
        .id_rd                (id_rd),
        .id_rd_wen            (id_rd_wen),
        .id_is_load           (id_is_load),
        .pipe_hold            (pipe_hold),
        .ex_flush             (ex_flush),
        .exu_src1_forward_ex  (exu_src1_forward_ex),
        .exu_src2_forward_ex  (exu_src2_forward_ex),
        .exu_src1_forward_mem (exu_src1_forward_mem),
        .exu_src2_forward_mem (exu_src2_forward_mem),
        .id_stall             (id_stall),
        .stall_cnt            (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reset cycles carry no expectation: state before the first edge is undefined.
    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1; pipe_hold = 1'b1; ex_flush = 1'b0; id_valid = 1'b1;
        id_rs1 = 5'd5; id_rs2 = 5'd5; id_rs1_ren = 1'b1; id_rs2_ren = 1'b1;
        id_rd = 5'd5; id_rd_wen = 1'b1; id_is_load = 1'b1;
    endtask

    // Drives one cycle of ID inputs and queues what the monitor must see this cycle:
    // eStall for this ID instruction, eFwd {s1ex,s2ex,s1mem,s2mem} for the one now in EX, eCnt so far.
    task automatic applyStimulus(input logic iRst, input logic iHold, input logic iFlush, input logic iValid,
                                 input int iRs1, input logic iRen1, input int iRs2, input logic iRen2,
                                 input int iRd, input logic iWen, input logic iLd,
                                 input logic eStall, input logic [3:0] eFwd, input int eCnt);
        expect_t e;
        @(negedge clk);
        rst = iRst; pipe_hold = iHold; ex_flush = iFlush; id_valid = iValid;
        id_rs1 = 5'(iRs1); id_rs1_ren = iRen1; id_rs2 = 5'(iRs2); id_rs2_ren = iRen2;
        id_rd = 5'(iRd); id_rd_wen = iWen; id_is_load = iLd;
        stepNum++;
        e.step  = stepNum;
        e.stall = eStall;
        e.fwd   = eFwd;
        e.cnt   = 64'(eCnt);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        logic [3:0] fwdNow;
        fwdNow = {exu_src1_forward_ex, exu_src2_forward_ex, exu_src1_forward_mem, exu_src2_forward_mem};
        nCompared++;
        if (id_stall !== e.stall) begin
            nMismatched++;
            $display("[TB] FAIL step %0d id_stall: got %0b expected %0b", e.step, id_stall, e.stall);
        end
        nCompared++;
        if (fwdNow !== e.fwd) begin
            nMismatched++;
            $display("[TB] FAIL step %0d forward{s1ex,s2ex,s1mem,s2mem}: got %4b expected %4b", e.step, fwdNow, e.fwd);
        end
        nCompared++;
        if (stall_cnt !== e.cnt) begin
            nMismatched++;
            $display("[TB] FAIL step %0d stall_cnt: got %0d expected %0d", e.step, stall_cnt, e.cnt);
        end
    endtask

    // Monitor: samples mid-low-phase, well away from the rising edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        rst = 1'b1; pipe_hold = 1'b1; ex_flush = 1'b0; id_valid = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rs1_ren = 1'b0; id_rs2_ren = 1'b0;
        id_rd = '0; id_rd_wen = 1'b0; id_is_load = 1'b0;
        applyReset();
        applyReset();

`ifdef FORWARD_CTRL_FORWARD_EN
        $display("[TB] build with forwarding enabled");
        // add x5 ; add x6,x5,x1 -> src1 forwarded from EX, no stall
        applyStimulus(0,0,0,1,  1,1,  2,1,  5,1,0,  0,4'b0000,0);
        applyStimulus(0,0,0,1,  5,1,  1,1,  6,1,0,  0,4'b0000,0);
        // ld x7 ; add x8,x1,x7 -> one load-use stall, then src2 from MEM
        applyStimulus(0,0,0,1,  3,1,  0,0,  7,1,1,  0,4'b1000,0);
        applyStimulus(0,0,0,1,  1,1,  7,1,  8,1,0,  1,4'b0000,0);
        applyStimulus(0,0,0,1,  1,1,  7,1,  8,1,0,  0,4'b0000,1);
        // add x0 ; reader of x0 -> nothing forwarded
        applyStimulus(0,0,0,1,  1,1,  2,1,  0,1,0,  0,4'b0001,1);
        applyStimulus(0,0,0,1,  0,1,  0,1, 11,1,0,  0,4'b0000,1);
        // add x9 ; add x9 ; sub x10,x9,x9 -> youngest (EX) wins on both sources
        applyStimulus(0,0,0,1,  1,1,  2,1,  9,1,0,  0,4'b0000,1);
        applyStimulus(0,0,0,1,  3,1,  4,1,  9,1,0,  0,4'b0000,1);
        applyStimulus(0,0,0,1,  9,1,  9,1, 10,1,0,  0,4'b0000,1);
        // MEM-only forward, then read-enables gate matches
        applyStimulus(0,0,0,1,  9,1,  3,1, 12,1,0,  0,4'b1100,1);
        applyStimulus(0,0,0,1, 12,0, 10,0, 13,1,0,  0,4'b0010,1);
        // ld x14 ; load-use held by pipe_hold for three cycles, released once
        applyStimulus(0,0,0,1,  1,1,  0,0, 14,1,1,  0,4'b0000,1);
        applyStimulus(0,1,0,1, 14,1,  2,1, 15,1,0,  1,4'b0000,1);
        applyStimulus(0,1,0,1, 14,1,  2,1, 15,1,0,  1,4'b0000,1);
        applyStimulus(0,1,0,1, 14,1,  2,1, 15,1,0,  1,4'b0000,1);
        applyStimulus(0,0,0,1, 14,1,  2,1, 15,1,0,  1,4'b0000,1);
        applyStimulus(0,0,0,1, 14,1,  2,1, 15,1,0,  0,4'b0000,2);
        applyStimulus(0,0,0,0,  0,0,  0,0,  0,0,0,  0,4'b0010,2);
        // pipe_hold freezes a live forward output
        applyStimulus(0,0,0,1,  1,1,  2,1, 16,1,0,  0,4'b0000,2);
        applyStimulus(0,0,0,1, 16,1,  0,1, 17,1,0,  0,4'b0000,2);
        applyStimulus(0,1,0,0,  0,0,  0,0,  0,0,0,  0,4'b1000,2);
        applyStimulus(0,0,0,0,  0,0,  0,0,  0,0,0,  0,4'b1000,2);
        // flush together with load-use, then flush alone suppresses a MEM forward
        applyStimulus(0,0,0,1,  1,1,  0,0, 18,1,1,  0,4'b0000,2);
        applyStimulus(0,0,1,1, 18,1, 18,1, 19,1,0,  1,4'b0000,2);
        applyStimulus(0,0,1,1, 18,1,  1,1, 20,1,0,  0,4'b0000,3);
        applyStimulus(0,0,0,0,  0,0,  0,0,  0,0,0,  0,4'b0000,3);
        // reset overrides pipe_hold
        applyStimulus(1,1,0,0,  0,0,  0,0,  0,0,0,  0,4'b0000,3);
        applyStimulus(0,0,0,1, 18,1, 18,1, 21,1,0,  0,4'b0000,0);
        applyStimulus(0,0,0,0,  0,0,  0,0,  0,0,0,  0,4'b0000,0);
`else
        $display("[TB] build with forwarding disabled");
        // add x5 ; reader of x5 -> three stall cycles while x5 drains to WB
        applyStimulus(0,0,0,1,  1,1,  2,1,  5,1,0,  0,4'b0000,0);
        applyStimulus(0,0,0,1,  5,1,  1,1,  6,1,0,  1,4'b0000,0);
        applyStimulus(0,0,0,1,  5,1,  1,1,  6,1,0,  1,4'b0000,1);
        applyStimulus(0,0,0,1,  5,1,  1,1,  6,1,0,  1,4'b0000,2);
        applyStimulus(0,0,0,1,  5,1,  1,1,  6,1,0,  0,4'b0000,3);
        // unrelated load, x0 writer, x0 reader
        applyStimulus(0,0,0,1,  3,1,  0,0,  7,1,1,  0,4'b0000,3);
        applyStimulus(0,0,0,1,  1,1,  2,1,  0,1,0,  0,4'b0000,3);
        applyStimulus(0,0,0,1,  0,1,  0,1, 11,1,0,  0,4'b0000,3);
        // matches masked by read-enables, then by id_valid
        applyStimulus(0,0,0,1,  7,0, 11,0, 12,1,0,  0,4'b0000,3);
        applyStimulus(0,0,0,0, 12,1, 11,1,  0,0,0,  0,4'b0000,3);
        // WB hit stalled under pipe_hold, counted only once released
        applyStimulus(0,1,0,1, 11,1,  1,1, 13,1,0,  1,4'b0000,3);
        applyStimulus(0,1,0,1, 11,1,  1,1, 13,1,0,  1,4'b0000,3);
        applyStimulus(0,0,0,1, 11,1,  1,1, 13,1,0,  1,4'b0000,3);
        applyStimulus(0,0,0,1, 11,1,  1,1, 13,1,0,  0,4'b0000,4);
        // flush together with a stall, then flush alone
        applyStimulus(0,0,1,1, 13,1,  1,1, 14,1,0,  1,4'b0000,4);
        applyStimulus(0,0,1,1,  1,1,  2,1, 15,1,0,  0,4'b0000,5);
        // reset overrides pipe_hold and clears the WB entry holding x13
        applyStimulus(1,1,0,0,  0,0,  0,0,  0,0,0,  0,4'b0000,5);
        applyStimulus(0,0,0,1, 13,1,  1,1, 16,1,0,  0,4'b0000,0);
`endif

        repeat (3) @(negedge clk);
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
